// File: rtl/e203_exu_lpwb_arb_if.sv
// Long-pipe writeback arbiter bundle: LSU/MULDIV completions, OITF oldest entry, regfile writeback.
// The arbiter connects through the slave modport and its environment through the master modport.
interface e203_exu_lpwb_arb_if #(
    parameter int XLEN    = 32,
    parameter int ITAG_W  = 3,
    parameter int RFIDX_W = 5,
    parameter int PC_W    = 32
);
    logic               lsu_wbck_i_valid;
    logic               lsu_wbck_i_ready;
    logic [XLEN-1:0]    lsu_wbck_i_wdat;
    logic [ITAG_W-1:0]  lsu_wbck_i_itag;
    logic               lsu_wbck_i_err;

    logic               muldiv_wbck_i_valid;
    logic               muldiv_wbck_i_ready;
    logic [XLEN-1:0]    muldiv_wbck_i_wdat;
    logic [ITAG_W-1:0]  muldiv_wbck_i_itag;

    logic               oitf_empty;
    logic [ITAG_W-1:0]  oitf_ret_ptr;
    logic               oitf_ret_rdwen;
    logic [RFIDX_W-1:0] oitf_ret_rdidx;
    logic [PC_W-1:0]    oitf_ret_pc;
    logic               oitf_ret_ena;

    logic               lpwb_o_valid;
    logic               lpwb_o_ready;
    logic [XLEN-1:0]    lpwb_o_wdat;
    logic [RFIDX_W-1:0] lpwb_o_rdidx;
    logic               lpwb_o_rdwen;
    logic               lpwb_o_err;
    logic [PC_W-1:0]    lpwb_o_pc;

    modport slave (
        input  lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_itag, lsu_wbck_i_err,
        output lsu_wbck_i_ready,
        input  muldiv_wbck_i_valid, muldiv_wbck_i_wdat, muldiv_wbck_i_itag,
        output muldiv_wbck_i_ready,
        input  oitf_empty, oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdidx, oitf_ret_pc,
        output oitf_ret_ena,
        output lpwb_o_valid, lpwb_o_wdat, lpwb_o_rdidx, lpwb_o_rdwen, lpwb_o_err, lpwb_o_pc,
        input  lpwb_o_ready
    );

    modport master (
        output lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_itag, lsu_wbck_i_err,
        input  lsu_wbck_i_ready,
        output muldiv_wbck_i_valid, muldiv_wbck_i_wdat, muldiv_wbck_i_itag,
        input  muldiv_wbck_i_ready,
        output oitf_empty, oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdidx, oitf_ret_pc,
        input  oitf_ret_ena,
        input  lpwb_o_valid, lpwb_o_wdat, lpwb_o_rdidx, lpwb_o_rdwen, lpwb_o_err, lpwb_o_pc,
        output lpwb_o_ready
    );
endinterface

// File: rtl/e203_exu_lpwb_arb.sv
// Retires long-pipe completions in OITF order through a one-entry writeback buffer.
// Define E203_LPWB_MULDIV_EN to arbitrate MULDIV alongside LSU; otherwise LSU only.
module e203_exu_lpwb_arb #(
    parameter int XLEN    = 32,
    parameter int ITAG_W  = 3,
    parameter int RFIDX_W = 5,
    parameter int PC_W    = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    e203_exu_lpwb_arb_if.slave  bus_io
);

    typedef struct packed {
        logic [XLEN-1:0]    wdat;
        logic [RFIDX_W-1:0] rdidx;
        logic               rdwen;
        logic               err;
        logic [PC_W-1:0]    pc;
    } wb_t;

    logic buf_vld_q, buf_vld_d;
    wb_t  buf_q, buf_d, win_pay;
    logic lsu_elig, md_elig, room, accept, load, pop;

    // Eligibility is a plain tag equality, so itag wrap-around needs no special case.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lsu_elig = !rst_n && !bus_io.oitf_empty && bus_io.lsu_wbck_i_valid
                   && (bus_io.lsu_wbck_i_itag == bus_io.oitf_ret_ptr);
`ifdef E203_LPWB_MULDIV_EN
        md_elig  = !rst_n && !bus_io.oitf_empty && bus_io.muldiv_wbck_i_valid
                   && (bus_io.muldiv_wbck_i_itag == bus_io.oitf_ret_ptr);
`else
        md_elig  = 1'b0;
`endif
        room   = !buf_vld_q || bus_io.lpwb_o_ready;
        accept = (lsu_elig || md_elig) && room;
    end

`ifndef E203_LPWB_MULDIV_EN
    logic md_unused;
    assign md_unused = &{1'b0, bus_io.muldiv_wbck_i_valid, bus_io.muldiv_wbck_i_itag};
`endif

    // LSU wins ties; rd info always comes from the oldest OITF entry.
    always_comb begin
        win_pay       = '0;
        win_pay.rdidx = bus_io.oitf_ret_rdidx;
        win_pay.rdwen = bus_io.oitf_ret_rdwen;
        win_pay.pc    = bus_io.oitf_ret_pc;
        if (lsu_elig) begin
            win_pay.wdat = bus_io.lsu_wbck_i_wdat;
            win_pay.err  = bus_io.lsu_wbck_i_err;
        end else begin
            win_pay.wdat = bus_io.muldiv_wbck_i_wdat;
        end

        load      = accept && (bus_io.oitf_ret_rdwen || win_pay.err);
        pop       = buf_vld_q && bus_io.lpwb_o_ready;
        buf_vld_d = load || (buf_vld_q && !pop);
        buf_d     = load ? win_pay : buf_q;
    end

    // NOTE: non-blocking assignments here; all next-state math lives in always_comb.
    // NOTE: payload is cleared with buf_vld so lpwb_o_* never shows stale data after reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            buf_vld_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            buf_q     <= buf_d;
        end
    end

    assign bus_io.lsu_wbck_i_ready    = lsu_elig && room;
    assign bus_io.muldiv_wbck_i_ready = md_elig && !lsu_elig && room;
    assign bus_io.oitf_ret_ena        = accept;

    assign bus_io.lpwb_o_valid = buf_vld_q && !rst_n;
    assign bus_io.lpwb_o_wdat  = buf_q.wdat;
    assign bus_io.lpwb_o_rdidx = buf_q.rdidx;
    assign bus_io.lpwb_o_rdwen = buf_q.rdwen;
    assign bus_io.lpwb_o_err   = buf_q.err;
    assign bus_io.lpwb_o_pc    = buf_q.pc;

endmodule

// File: tb/tb_e203_exu_lpwb_arb.sv
// Self-checking bench for e203_exu_lpwb_arb: directed scenarios then random traffic,
// all checked against a queue-based model of in-order retirement through one buffer slot.
module tb_e203_exu_lpwb_arb;
    localparam int XLEN = 32, ITAG_W = 3, RFIDX_W = 5, PC_W = 32;
`ifdef E203_LPWB_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    e203_exu_lpwb_arb_if #(.XLEN(XLEN), .ITAG_W(ITAG_W), .RFIDX_W(RFIDX_W), .PC_W(PC_W)) bus ();
    e203_exu_lpwb_arb #(.XLEN(XLEN), .ITAG_W(ITAG_W), .RFIDX_W(RFIDX_W), .PC_W(PC_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    typedef struct {
        logic [XLEN-1:0]    wdat;
        logic [RFIDX_W-1:0] rdidx;
        logic               rdwen;
        logic               err;
        logic [PC_W-1:0]    pc;
    } wb_t;

    wb_t  wb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic e_lsu_rdy, e_md_rdy, e_ret;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle after the input change, derive expectations from the retirement rules, compare.
    task automatic eval_check();
        bit full, lsu_ok, md_ok, room;
        #1;
        full   = (wb_q.size() != 0);
        lsu_ok = !rst_n && !bus.oitf_empty && bus.lsu_wbck_i_valid
                 && (bus.lsu_wbck_i_itag == bus.oitf_ret_ptr);
        md_ok  = MD_EN && !rst_n && !bus.oitf_empty && bus.muldiv_wbck_i_valid
                 && (bus.muldiv_wbck_i_itag == bus.oitf_ret_ptr);
        room   = !full || bus.lpwb_o_ready;
        e_lsu_rdy = lsu_ok && room;
        e_md_rdy  = md_ok && !lsu_ok && room;
        e_ret     = e_lsu_rdy || e_md_rdy;
        check("lsu_ready",    bus.lsu_wbck_i_ready,    e_lsu_rdy);
        check("muldiv_ready", bus.muldiv_wbck_i_ready, e_md_rdy);
        check("oitf_ret_ena", bus.oitf_ret_ena,        e_ret);
        check("lpwb_valid",   bus.lpwb_o_valid,        full && !rst_n);
        if (full && !rst_n) begin
            check("lpwb_wdat",  bus.lpwb_o_wdat,  wb_q[0].wdat);
            check("lpwb_rdidx", bus.lpwb_o_rdidx, wb_q[0].rdidx);
            check("lpwb_rdwen", bus.lpwb_o_rdwen, wb_q[0].rdwen);
            check("lpwb_err",   bus.lpwb_o_err,   wb_q[0].err);
            check("lpwb_pc",    bus.lpwb_o_pc,    wb_q[0].pc);
        end
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        wb_t e;
        @(posedge clk);
        if (rst_n) begin
            wb_q.delete();
        end else begin
            if (wb_q.size() != 0 && bus.lpwb_o_ready) void'(wb_q.pop_front());
            if (e_ret) begin
                e.wdat  = e_lsu_rdy ? bus.lsu_wbck_i_wdat : bus.muldiv_wbck_i_wdat;
                e.err   = e_lsu_rdy ? bus.lsu_wbck_i_err : 1'b0;
                e.rdidx = bus.oitf_ret_rdidx;
                e.rdwen = bus.oitf_ret_rdwen;
                e.pc    = bus.oitf_ret_pc;
                if (e.rdwen || e.err) wb_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        eval_check();
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        bus.lsu_wbck_i_valid = 1'b0; bus.lsu_wbck_i_wdat = '0; bus.lsu_wbck_i_itag = '0;
        bus.lsu_wbck_i_err = 1'b0;
        bus.muldiv_wbck_i_valid = 1'b0; bus.muldiv_wbck_i_wdat = '0; bus.muldiv_wbck_i_itag = '0;
        bus.oitf_empty = 1'b0; bus.oitf_ret_ptr = '0; bus.oitf_ret_rdwen = 1'b0;
        bus.oitf_ret_rdidx = '0; bus.oitf_ret_pc = '0; bus.lpwb_o_ready = 1'b0;
        @(negedge clk);

        // Reset held with an eligible LSU request: nothing may be accepted.
        bus.lsu_wbck_i_valid = 1'b1; bus.oitf_ret_rdwen = 1'b1; bus.lpwb_o_ready = 1'b1;
        step();
        eval_check();
        check("rst_ready", bus.lsu_wbck_i_ready, 1'b0);
        check("rst_wdat",  bus.lpwb_o_wdat,  '0);
        check("rst_rdidx", bus.lpwb_o_rdidx, '0);
        check("rst_pc",    bus.lpwb_o_pc,    '0);
        tick();

        // Basic load, first cycle out of reset.
        rst_n = 1'b0;
        bus.oitf_ret_ptr = 3'd3; bus.oitf_ret_rdidx = 5'd5; bus.oitf_ret_pc = 32'h8000_0010;
        bus.lsu_wbck_i_itag = 3'd3; bus.lsu_wbck_i_wdat = 32'hDEAD_BEEF; bus.lpwb_o_ready = 1'b0;
        eval_check();
        check("basic_ready", bus.lsu_wbck_i_ready, 1'b1);
        check("basic_ret",   bus.oitf_ret_ena,     1'b1);
        tick();
        bus.lsu_wbck_i_valid = 1'b0;
        eval_check();
        check("basic_valid", bus.lpwb_o_valid, 1'b1);
        check("basic_wdat",  bus.lpwb_o_wdat,  32'hDEAD_BEEF);
        check("basic_rdidx", bus.lpwb_o_rdidx, 5'd5);
        tick();

        // Backpressure hold, then pop and load in the same cycle.
        bus.lsu_wbck_i_valid = 1'b1; bus.lsu_wbck_i_wdat = 32'h1234_5678; bus.oitf_ret_rdidx = 5'd7;
        for (int i = 0; i < 3; i++) begin
            eval_check();
            check("hold_ready", bus.lsu_wbck_i_ready, 1'b0);
            check("hold_wdat",  bus.lpwb_o_wdat,      32'hDEAD_BEEF);
            tick();
        end
        bus.lpwb_o_ready = 1'b1;
        eval_check();
        check("swap_ready", bus.lsu_wbck_i_ready, 1'b1);
        tick();
        bus.lsu_wbck_i_valid = 1'b0; bus.lpwb_o_ready = 1'b0;
        eval_check();
        check("swap_valid", bus.lpwb_o_valid, 1'b1);
        check("swap_wdat",  bus.lpwb_o_wdat,  32'h1234_5678);
        tick();
        bus.lpwb_o_ready = 1'b1;
        step();
        bus.lpwb_o_ready = 1'b0;
        eval_check();
        check("drain_valid", bus.lpwb_o_valid, 1'b0);
        tick();

        // Store retire without writeback, then an erroring store that must report.
        bus.oitf_ret_ptr = 3'd1; bus.lsu_wbck_i_itag = 3'd1; bus.oitf_ret_rdwen = 1'b0;
        bus.lsu_wbck_i_valid = 1'b1; bus.lsu_wbck_i_err = 1'b0;
        eval_check();
        check("store_ret", bus.oitf_ret_ena, 1'b1);
        tick();
        bus.lsu_wbck_i_valid = 1'b0;
        eval_check();
        check("store_novalid", bus.lpwb_o_valid, 1'b0);
        tick();
        bus.lsu_wbck_i_valid = 1'b1; bus.lsu_wbck_i_err = 1'b1; bus.oitf_ret_pc = 32'h0000_4444;
        step();
        bus.lsu_wbck_i_valid = 1'b0; bus.lsu_wbck_i_err = 1'b0;
        eval_check();
        check("err_valid", bus.lpwb_o_valid, 1'b1);
        check("err_flag",  bus.lpwb_o_err,   1'b1);
        check("err_pc",    bus.lpwb_o_pc,    32'h0000_4444);
        tick();
        bus.lpwb_o_ready = 1'b1;
        step();

        // Ordering: MULDIV holds the oldest tag, LSU must wait.
        bus.oitf_ret_rdwen = 1'b1; bus.oitf_ret_ptr = 3'd3;
        bus.lsu_wbck_i_valid = 1'b1; bus.lsu_wbck_i_itag = 3'd2; bus.lsu_wbck_i_wdat = 32'h0000_00AA;
        bus.muldiv_wbck_i_valid = 1'b1; bus.muldiv_wbck_i_itag = 3'd3;
        bus.muldiv_wbck_i_wdat = 32'h0000_CAFE;
        eval_check();
        check("order_lsu", bus.lsu_wbck_i_ready,    1'b0);
        check("order_md",  bus.muldiv_wbck_i_ready, MD_EN);
        tick();
        bus.muldiv_wbck_i_valid = 1'b0; bus.oitf_ret_ptr = 3'd2;
        eval_check();
        check("order_lsu2", bus.lsu_wbck_i_ready, 1'b1);
        tick();

        // Tie on the same tag: LSU wins.
        bus.oitf_ret_ptr = 3'd4; bus.lsu_wbck_i_itag = 3'd4; bus.muldiv_wbck_i_itag = 3'd4;
        bus.muldiv_wbck_i_valid = 1'b1;
        eval_check();
        check("tie_lsu", bus.lsu_wbck_i_ready,    1'b1);
        check("tie_md",  bus.muldiv_wbck_i_ready, 1'b0);
        tick();
        bus.lsu_wbck_i_valid = 1'b0; bus.muldiv_wbck_i_valid = 1'b0;
        eval_check();
        check("tie_wdat", bus.lpwb_o_wdat, 32'h0000_00AA);
        tick();

        // MULDIV alone on the oldest tag.
        bus.muldiv_wbck_i_valid = 1'b1;
        eval_check();
        check("md_alone", bus.muldiv_wbck_i_ready, MD_EN);
        tick();
        bus.muldiv_wbck_i_valid = 1'b0;
        step();

        // Reset while the buffer holds an entry.
        bus.lpwb_o_ready = 1'b0; bus.oitf_ret_ptr = 3'd5; bus.lsu_wbck_i_itag = 3'd5;
        bus.lsu_wbck_i_valid = 1'b1;
        step();
        bus.lsu_wbck_i_valid = 1'b0;
        eval_check();
        check("pre_rst_valid", bus.lpwb_o_valid, 1'b1);
        tick();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        eval_check();
        check("post_rst_valid", bus.lpwb_o_valid, 1'b0);
        tick();

        // Random traffic with small tag space so matches and wrap-around are frequent.
        for (int i = 0; i < 800; i++) begin
            rst_n                   = ($urandom_range(0, 79) == 0);
            bus.oitf_empty          = ($urandom_range(0, 9) == 0);
            bus.oitf_ret_ptr        = ITAG_W'($urandom_range(0, 7));
            bus.oitf_ret_rdwen      = ($urandom_range(0, 3) != 0);
            bus.oitf_ret_rdidx      = RFIDX_W'($urandom);
            bus.oitf_ret_pc         = $urandom;
            bus.lsu_wbck_i_valid    = $urandom_range(0, 1);
            bus.lsu_wbck_i_itag     = $urandom_range(0, 1) ? bus.oitf_ret_ptr : ITAG_W'($urandom);
            bus.lsu_wbck_i_wdat     = $urandom;
            bus.lsu_wbck_i_err      = ($urandom_range(0, 4) == 0);
            bus.muldiv_wbck_i_valid = $urandom_range(0, 1);
            bus.muldiv_wbck_i_itag  = $urandom_range(0, 1) ? bus.oitf_ret_ptr : ITAG_W'($urandom);
            bus.muldiv_wbck_i_wdat  = $urandom;
            bus.lpwb_o_ready        = $urandom_range(0, 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e203_exu_lpwb_arb.md
E203_EXU_LPWB_ARB -- requirements
Module: e203_exu_lpwb_arb

Interface
REQ-001 SHALL have one clock, clk; reset is rst_n, synchronous, active-high (asserted when 1), sampled on rising clk only.
REQ-002 clk  in  1  core clock.
REQ-003 rst_n  in  1  synchronous active-high reset.
REQ-004 lsu_wbck_i_valid / lsu_wbck_i_ready  in / out  1 / 1  LSU completion handshake.
REQ-005 lsu_wbck_i_wdat  in  E203_XLEN  LSU result data.
REQ-006 lsu_wbck_i_itag  in  E203_ITAG_WIDTH  OITF tag of LSU completion.
REQ-007 lsu_wbck_i_err  in  1  LSU bus/misalign error flag.
REQ-008 muldiv_wbck_i_valid / muldiv_wbck_i_ready  in / out  1 / 1  MULDIV completion handshake.
REQ-009 muldiv_wbck_i_wdat / muldiv_wbck_i_itag  in  E203_XLEN / E203_ITAG_WIDTH  MULDIV result and tag.
REQ-010 oitf_empty  in  1  OITF holds no entries.
REQ-011 oitf_ret_ptr  in  E203_ITAG_WIDTH  tag of oldest OITF entry.
REQ-012 oitf_ret_rdwen / oitf_ret_rdidx / oitf_ret_pc  in  1 / E203_RFIDX_WIDTH / E203_PC_SIZE  oldest entry info.
REQ-013 oitf_ret_ena  out  1  pops oldest OITF entry.
REQ-014 lpwb_o_valid / lpwb_o_ready  out / in  1 / 1  writeback handshake to regfile/commit.
REQ-015 lpwb_o_wdat / lpwb_o_rdidx / lpwb_o_rdwen  out  E203_XLEN / E203_RFIDX_WIDTH / 1  writeback payload.
REQ-016 lpwb_o_err / lpwb_o_pc  out  1 / E203_PC_SIZE  error flag and faulting pc.

Function
REQ-017 Requester eligible SHALL mean valid=1, itag==oitf_ret_ptr, oitf_empty=0; completions retire strictly in OITF order.
REQ-018 Both eligible in same cycle: LSU SHALL win; MULDIV ready=0 that cycle.
REQ-019 Accept condition: winner eligible and (buf_vld=0 or lpwb_o_ready=1); only then winner ready=1.
REQ-020 oitf_ret_ena SHALL equal 1 exactly in cycles an acceptance occurs (combinational, same cycle).
REQ-021 Non-eligible or non-winning requester ready SHALL be 0; oitf_empty=1 forces all ready=0.
REQ-022 One-entry output buffer (buf_vld + payload); lpwb_o_* driven only from buffer; lpwb_o_valid=buf_vld.
REQ-023 Accepted completion with oitf_ret_rdwen=1 or err=1 SHALL load buffer; lpwb_o_valid high next cycle (latency 1).
REQ-024 Loaded payload: wdat from winner, rdidx/rdwen/pc from OITF oldest entry, err=lsu_wbck_i_err if LSU else 0.
REQ-025 Accepted completion with rdwen=0 and err=0 SHALL retire (oitf_ret_ena=1) without loading buffer.
REQ-026 Buffer pop (lpwb_o_valid & lpwb_o_ready) with no load SHALL clear buf_vld next cycle.
REQ-027 Pop and load in same cycle SHALL keep buf_vld=1 with new payload; no bubble, no lost entry.
REQ-028 Buffer held with lpwb_o_ready=0 SHALL keep payload stable; no new acceptance.
REQ-029 Tag wrap-around handled by equality compare only; no ordering arithmetic on itags.

Reset
REQ-030 rst_n=1 SHALL clear buf_vld and buffer payload to 0 at next clk edge.
REQ-031 During reset all ready outputs, oitf_ret_ena, lpwb_o_valid SHALL be 0; in-flight buffer contents discarded.
REQ-032 First acceptance possible in first cycle after rst_n deasserts.

Configuration
REQ-033 Macro E203_LPWB_MULDIV_EN defined: MULDIV requester arbitrated per REQ-017..REQ-018.
REQ-034 Macro undefined: MULDIV ports remain, muldiv_wbck_i_ready tied 0, MULDIV inputs ignored; LSU-only behaviour otherwise identical.

Verification
REQ-035 oitf_ret_ptr=3, rdwen=1, rdidx=5, LSU valid itag=3 wdat=0xDEAD_BEEF -> ready and oitf_ret_ena same cycle; next cycle lpwb_o_valid=1, wdat=0xDEADBEEF, rdidx=5.
REQ-036 LSU itag=2, MULDIV itag=3, ret_ptr=3 -> MULDIV accepted, LSU ready=0; ptr then 2 -> LSU accepted.
REQ-037 Both itag=4 with ret_ptr=4 -> LSU ready=1, MULDIV ready=0.
REQ-038 Buffer full, lpwb_o_ready=0 for 3 cycles, LSU eligible -> no acceptance, payload stable; ready=1 -> pop and load same cycle, buf_vld stays 1.
REQ-039 Store retire: rdwen=0, err=0 -> oitf_ret_ena=1, lpwb_o_valid stays 0; same with err=1 -> lpwb_o_valid=1, err=1, pc=oitf_ret_pc.
REQ-040 rst_n=1 while buf_vld=1 -> next cycle lpwb_o_valid=0; macro undefined, MULDIV valid itag match -> muldiv ready stays 0.
